mem_arbiter: RTL and testbench

//  Shares the single unified instruction/data memory of the multicycle core between two requesters:
//  the core's memory port (port C) and a debug/DMA loader (port D).

---
 rtl/mem_arb_pkg.sv | 24 ++
 rtl/mem_arbiter_if.sv | 48 ++++
 rtl/mem_arbiter_rr2.sv | 34 +++
 rtl/mem_arbiter.sv | 111 +++++++++++
 tb/tb_mem_arbiter.sv | 356 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the unified-memory arbiter:
// FSM states, requester ids and grant encodings.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   typedef enum logic {
      PORT_C = 1'b0,
      PORT_D = 1'b1
   } port_t;

   localparam logic [1:0] GRANT_NONE = 2'b00;
   localparam logic [1:0] GRANT_C    = 2'b01;
   localparam logic [1:0] GRANT_D    = 2'b10;

   function automatic logic [1:0] grant_of(port_t p);
      return (p == PORT_D) ? GRANT_D : GRANT_C;
   endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of both requester ports and the memory macro port.
// slave = arbiter side, master = core/DMA/memory environment side.
interface mem_arbiter_if #(
   parameter int AW = 32,
   parameter int DW = 32
);
   logic          c_req;
   logic          c_we;
   logic [AW-1:0] c_adr;
   logic [DW-1:0] c_wdata;
   logic [DW-1:0] c_rdata;
   logic          c_ready;
   logic          c_stall;

   logic          d_req;
   logic          d_we;
   logic [AW-1:0] d_adr;
   logic [DW-1:0] d_wdata;
   logic [DW-1:0] d_rdata;
   logic          d_ready;

   logic          mem_en;
   logic          mem_we;
   logic [AW-1:0] mem_adr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;
   logic [1:0]    grant;

   modport slave (
      input  c_req, c_we, c_adr, c_wdata,
      output c_rdata, c_ready, c_stall,
      input  d_req, d_we, d_adr, d_wdata,
      output d_rdata, d_ready,
      output mem_en, mem_we, mem_adr, mem_wdata,
      input  mem_rdata,
      output grant
   );

   modport master (
      output c_req, c_we, c_adr, c_wdata,
      input  c_rdata, c_ready, c_stall,
      output d_req, d_we, d_adr, d_wdata,
      input  d_rdata, d_ready,
      input  mem_en, mem_we, mem_adr, mem_wdata,
      output mem_rdata,
      input  grant
   );
endinterface

// File: rtl/mem_arbiter_rr2.sv
// Two-way round-robin pick: on a tie the port that
// did not win last time is chosen.
module arb_rr2
   import mem_arb_pkg::*;
(
   input  logic  i_c_req,
   input  logic  i_d_req,
   input  port_t i_last,
   output port_t o_win,
   output logic  o_valid
);
   always_comb begin
      o_win   = PORT_C;
      o_valid = 1'b0;
      unique case ({i_c_req, i_d_req})
         2'b11: begin
            o_win   = (i_last == PORT_C) ? PORT_D : PORT_C;
            o_valid = 1'b1;
         end
         2'b10: begin
            o_win   = PORT_C;
            o_valid = 1'b1;
         end
         2'b01: begin
            o_win   = PORT_D;
            o_valid = 1'b1;
         end
         default: begin
            o_win   = PORT_C;
            o_valid = 1'b0;
         end
      endcase
   end
endmodule

// File: rtl/mem_arbiter.sv
// Serialises core and DMA accesses onto one fixed-latency
// memory: IDLE -> ACCESS (LAT cycles) -> RESP (1 cycle).
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int AW  = 32,
   parameter int DW  = 32,
   parameter int LAT = 2
) (
   input logic          clk,
   input logic          reset,
   mem_arbiter_if.slave bus
);
   localparam int            CW       = $clog2(LAT + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(LAT - 1);

   state_t        r_state;
   logic [CW-1:0] r_cnt;
   port_t         r_last;
   port_t         r_win;
   logic [1:0]    r_grant;
   logic          r_mem_en;
   logic          r_mem_we;
   logic [AW-1:0] r_mem_adr;
   logic [DW-1:0] r_mem_wdata;
   logic          r_c_ready;
   logic          r_d_ready;
   logic [DW-1:0] r_c_hold;
   logic [DW-1:0] r_d_hold;

   port_t w_win;
   logic  w_valid;

   arb_rr2 u_rr (
      .i_c_req (bus.c_req),
      .i_d_req (bus.d_req),
      .i_last  (r_last),
      .o_win   (w_win),
      .o_valid (w_valid)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_last      <= PORT_D;
         r_win       <= PORT_C;
         r_grant     <= GRANT_NONE;
         r_mem_en    <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_adr   <= '0;
         r_mem_wdata <= '0;
         r_c_ready   <= 1'b0;
         r_d_ready   <= 1'b0;
         r_c_hold    <= '0;
         r_d_hold    <= '0;
      end else begin
         unique case (r_state)
            IDLE: begin
               if (w_valid) begin
                  r_win    <= w_win;
                  r_last   <= w_win;
                  r_grant  <= grant_of(w_win);
                  r_cnt    <= '0;
                  r_mem_en <= 1'b1;
                  r_state  <= ACCESS;
                  if (w_win == PORT_D) begin
                     r_mem_we    <= bus.d_we;
                     r_mem_adr   <= bus.d_adr;
                     r_mem_wdata <= bus.d_wdata;
                  end else begin
                     r_mem_we    <= bus.c_we;
                     r_mem_adr   <= bus.c_adr;
                     r_mem_wdata <= bus.c_wdata;
                  end
               end
            end
            ACCESS: begin
               r_mem_en <= 1'b0;
               r_cnt    <= r_cnt + CW'(1);
               if (r_cnt == CNT_LAST) begin
                  r_state   <= RESP;
                  r_c_ready <= (r_win == PORT_C);
                  r_d_ready <= (r_win == PORT_D);
               end
            end
            RESP: begin
               r_c_ready <= 1'b0;
               r_d_ready <= 1'b0;
               r_grant   <= GRANT_NONE;
               r_state   <= IDLE;
               if (r_win == PORT_C) r_c_hold <= bus.mem_rdata;
               else                 r_d_hold <= bus.mem_rdata;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   // Read data bypasses the hold register during the ready cycle.
   assign bus.c_rdata   = r_c_ready ? bus.mem_rdata : r_c_hold;
   assign bus.d_rdata   = r_d_ready ? bus.mem_rdata : r_d_hold;
   assign bus.c_ready   = r_c_ready;
   assign bus.d_ready   = r_d_ready;
   assign bus.c_stall   = bus.c_req & ~r_c_ready;
   assign bus.mem_en    = r_mem_en;
   assign bus.mem_we    = r_mem_we;
   assign bus.mem_adr   = r_mem_adr;
   assign bus.mem_wdata = r_mem_wdata;
   assign bus.grant     = r_grant;
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table, corner
// sequences, random traffic vs. a timing model, LAT=1/15 builds.
module tb_mem_arbiter;
   localparam int LAT = 2;
   localparam int P   = LAT + 2;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   mem_arbiter_if #(.AW(32), .DW(32)) bus ();

   mem_arbiter #(.AW(32), .DW(32), .LAT(LAT)) dut (
      .clk   (clk),
      .reset (rst_n),
      .bus   (bus)
   );

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] dflt(input logic [31:0] a);
      return a ^ 32'hA5A5_0000;
   endfunction

   function automatic logic [31:0] wjunk(input logic [31:0] a);
      return a ^ 32'hFEED_0000;
   endfunction

   // Memory macro model: fixed LAT read latency, writes return junk.
   logic [31:0] mem [logic [31:0]];
   logic [31:0] slot_v [64];
   int          cyc = 0;

   initial begin
      bus.mem_rdata = '0;
      for (int i = 0; i < 64; i++) slot_v[i] = '0;
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         if (bus.mem_en) begin
            if (bus.mem_we) begin
               slot_v[(cyc + LAT) % 64] = wjunk(bus.mem_adr);
               mem[bus.mem_adr] = bus.mem_wdata;
            end else begin
               slot_v[(cyc + LAT) % 64] = mem.exists(bus.mem_adr) ?
                  mem[bus.mem_adr] : dflt(bus.mem_adr);
            end
         end
         bus.mem_rdata = slot_v[cyc % 64];
      end
   end

   // Extra builds with LAT=1 and LAT=15.
   bit lat_go = 1'b0;
   bit lat_done [2];

   for (genvar g = 0; g < 2; g++) begin : g_lat
      localparam int L = (g == 0) ? 1 : 15;
      mem_arbiter_if #(.AW(32), .DW(32)) lb ();
      mem_arbiter #(.AW(32), .DW(32), .LAT(L)) u (
         .clk   (clk),
         .reset (rst_n),
         .bus   (lb)
      );
      assign lb.mem_rdata = 32'h5A5A_0000 + L;
      initial begin
         int mens;
         int got;
         lat_done[g] = 1'b0;
         lb.c_req = 0; lb.c_we = 0; lb.c_adr = 0; lb.c_wdata = 0;
         lb.d_req = 0; lb.d_we = 0; lb.d_adr = 0; lb.d_wdata = 0;
         wait (lat_go);
         for (int rep = 0; rep < 2; rep++) begin
            @(negedge clk);
            lb.c_req = 1'b1;
            lb.c_adr = 32'h80 + 32'(rep * 4);
            mens = 0;
            got  = 0;
            for (int k = 1; k <= L + 3; k++) begin
               @(negedge clk);
               if (lb.mem_en) mens++;
               if (lb.c_ready) begin
                  if (got == 0) begin
                     chk("lat_ready_cycle", k, 1 + L);
                     chk("lat_rdata", lb.c_rdata, 32'h5A5A_0000 + L);
                  end
                  got++;
                  lb.c_req = 1'b0;
               end
            end
            chk("lat_ready_count", got, 1);
            chk("lat_mem_en_count", mens, 1);
         end
         lat_done[g] = 1'b1;
      end
   end

   typedef struct {
      logic        c_req;
      logic        c_we;
      logic [31:0] c_adr;
      logic [31:0] c_wdata;
      logic        d_req;
      logic        d_we;
      logic [31:0] d_adr;
      logic [31:0] d_wdata;
      int          port;
      logic [31:0] rdata;
   } vec_t;

   vec_t        tbl [6];
   logic [31:0] hold [2];

   // Random-phase driver and reference state.
   logic        rp [2];
   logic        rwe [2];
   logic [31:0] radr [2];
   logic [31:0] rwd [2];
   logic [31:0] ref_mem [logic [31:0]];

   task automatic clear_inputs();
      bus.c_req = 0; bus.c_we = 0; bus.c_adr = 0; bus.c_wdata = 0;
      bus.d_req = 0; bus.d_we = 0; bus.d_adr = 0; bus.d_wdata = 0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      clear_inputs();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      hold[0] = '0;
      hold[1] = '0;
   endtask

   initial begin
      int nrdy;
      int win, win_t, done_t, free_at, rlast;
      logic busy, exp_we;
      logic [31:0] exp_d, exp_a, exp_w;
      logic erc, erd;

      mem[32'h40] = 32'hDEAD_BEEF;
      clear_inputs();
      hold[0] = '0;
      hold[1] = '0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      chk("rst_c_rdata", bus.c_rdata, 0);
      chk("rst_d_rdata", bus.d_rdata, 0);
      chk("rst_c_ready", bus.c_ready, 0);
      chk("rst_d_ready", bus.d_ready, 0);
      chk("rst_c_stall", bus.c_stall, 0);
      chk("rst_mem_en", bus.mem_en, 0);
      chk("rst_mem_we", bus.mem_we, 0);
      chk("rst_mem_adr", bus.mem_adr, 0);
      chk("rst_mem_wdata", bus.mem_wdata, 0);
      chk("rst_grant", bus.grant, 0);

      tbl[0] = '{1, 0, 32'h40, 0, 0, 0, 0, 0, 0, 32'hDEAD_BEEF};
      tbl[1] = '{0, 0, 0, 0, 1, 1, 32'h100, 32'h1234_5678, 1, 32'hFEED_0100};
      tbl[2] = '{1, 0, 32'h100, 0, 0, 0, 0, 0, 0, 32'h1234_5678};
      tbl[3] = '{0, 0, 0, 0, 1, 0, 32'h200, 0, 1, 32'hA5A5_0200};
      tbl[4] = '{1, 1, 32'h44, 32'hCAFE_F00D, 0, 0, 0, 0, 0, 32'hFEED_0044};
      tbl[5] = '{0, 0, 0, 0, 1, 0, 32'h44, 0, 1, 32'hCAFE_F00D};

      for (int r = 0; r < 6; r++) begin
         vec_t v;
         logic [31:0] rd_p, rd_o;
         v = tbl[r];
         bus.c_req = v.c_req; bus.c_we = v.c_we;
         bus.c_adr = v.c_adr; bus.c_wdata = v.c_wdata;
         bus.d_req = v.d_req; bus.d_we = v.d_we;
         bus.d_adr = v.d_adr; bus.d_wdata = v.d_wdata;
         for (int k = 1; k <= LAT + 2; k++) begin
            @(negedge clk);
            rd_p = (v.port == 0) ? bus.c_rdata : bus.d_rdata;
            rd_o = (v.port == 0) ? bus.d_rdata : bus.c_rdata;
            if (k == 1) begin
               chk("vec_mem_en", bus.mem_en, 1);
               chk("vec_mem_we", bus.mem_we, v.port ? v.d_we : v.c_we);
               chk("vec_mem_adr", bus.mem_adr, v.port ? v.d_adr : v.c_adr);
               chk("vec_mem_wdata", bus.mem_wdata,
                   v.port ? v.d_wdata : v.c_wdata);
               chk("vec_grant", bus.grant, v.port ? 2'b10 : 2'b01);
            end
            if (k == 2) chk("vec_mem_en_drop", bus.mem_en, 0);
            if (k == 1 + LAT) begin
               chk("vec_c_ready", bus.c_ready, v.port == 0);
               chk("vec_d_ready", bus.d_ready, v.port == 1);
               chk("vec_rdata", rd_p, v.rdata);
               chk("vec_other_rdata", rd_o, hold[1 - v.port]);
               clear_inputs();
            end
            if (k == LAT + 2) begin
               chk("vec_grant_idle", bus.grant, 0);
               chk("vec_ready_idle", bus.c_ready | bus.d_ready, 0);
               chk("vec_rdata_hold", rd_p, v.rdata);
            end
         end
         hold[v.port] = v.rdata;
      end

      // Reset while an access is in flight.
      do_reset();
      bus.c_req = 1'b1;
      bus.c_adr = 32'h48;
      @(negedge clk);
      chk("abort_mem_en_before", bus.mem_en, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("abort_mem_en_async", bus.mem_en, 0);
      chk("abort_grant", bus.grant, 0);
      @(negedge clk);
      bus.c_req = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      nrdy = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (bus.c_ready | bus.d_ready) nrdy++;
      end
      chk("abort_no_ready", nrdy, 0);
      chk("abort_c_rdata", bus.c_rdata, 0);

      // Both requesting continuously right after reset.
      do_reset();
      bus.c_req = 1'b1; bus.c_adr = 32'h40;
      bus.d_req = 1'b1; bus.d_adr = 32'h200;
      for (int t = 1; t <= 1 + 7 * P + LAT; t++) begin
         int k, ph;
         @(negedge clk);
         k  = (t - 1) / P;
         ph = (t - 1) % P;
         chk("rr_mem_en", bus.mem_en, ph == 0);
         chk("rr_grant", bus.grant,
             (ph <= LAT) ? ((k % 2) ? 2'b10 : 2'b01) : 2'b00);
         chk("rr_c_ready", bus.c_ready, ph == LAT && k % 2 == 0);
         chk("rr_d_ready", bus.d_ready, ph == LAT && k % 2 == 1);
         if (ph == LAT && k % 2 == 0) chk("rr_c_rdata", bus.c_rdata, 32'hDEAD_BEEF);
         if (ph == LAT && k % 2 == 1) chk("rr_d_rdata", bus.d_rdata, 32'hA5A5_0200);
      end
      clear_inputs();
      @(negedge clk);

      // DMA arrives mid-access; its address is sampled at grant.
      bus.c_req = 1'b1; bus.c_adr = 32'h40;
      @(negedge clk);
      @(negedge clk);
      bus.d_req = 1'b1; bus.d_adr = 32'h300;
      @(negedge clk);
      chk("late_c_ready", bus.c_ready, 1);
      chk("late_c_rdata", bus.c_rdata, 32'hDEAD_BEEF);
      bus.c_req = 1'b0;
      bus.d_adr = 32'h304;
      @(negedge clk);
      chk("late_idle_grant", bus.grant, 0);
      chk("late_idle_mem_en", bus.mem_en, 0);
      @(negedge clk);
      chk("late_d_mem_en", bus.mem_en, 1);
      chk("late_d_adr", bus.mem_adr, 32'h304);
      chk("late_d_grant", bus.grant, 2'b10);
      bus.d_adr = 32'h308;
      @(negedge clk);
      @(negedge clk);
      chk("late_d_ready", bus.d_ready, 1);
      chk("late_d_rdata", bus.d_rdata, 32'hA5A5_0304);
      bus.d_req = 1'b0;
      @(negedge clk);
      chk("late_d_hold", bus.d_rdata, 32'hA5A5_0304);

      // Random traffic against a cycle-arithmetic reference.
      do_reset();
      ref_mem = mem;
      for (int p = 0; p < 2; p++) begin
         rp[p] = 0; rwe[p] = 0; radr[p] = 0; rwd[p] = 0;
      end
      busy = 0; win = 0; win_t = 0; done_t = 0; free_at = 0; rlast = 1;
      exp_d = 0; exp_a = 0; exp_w = 0; exp_we = 0;
      for (int t = 0; t < 400; t++) begin
         if (t > 0) @(negedge clk);
         erc = busy && t == done_t && win == 0;
         erd = busy && t == done_t && win == 1;
         chk("rnd_c_ready", bus.c_ready, erc);
         chk("rnd_d_ready", bus.d_ready, erd);
         chk("rnd_grant", bus.grant,
             (busy && t > win_t) ? (win ? 2'b10 : 2'b01) : 2'b00);
         chk("rnd_mem_en", bus.mem_en, busy && t == win_t + 1);
         chk("rnd_c_stall", bus.c_stall, rp[0] & ~erc);
         chk("rnd_c_rdata", bus.c_rdata, erc ? exp_d : hold[0]);
         chk("rnd_d_rdata", bus.d_rdata, erd ? exp_d : hold[1]);
         if (busy && t == win_t + 1) begin
            chk("rnd_mem_adr", bus.mem_adr, exp_a);
            chk("rnd_mem_we", bus.mem_we, exp_we);
            chk("rnd_mem_wdata", bus.mem_wdata, exp_w);
         end
         if (busy && t == done_t) begin
            hold[win] = exp_d;
            rp[win] = 0;
            busy = 0;
         end
         for (int p = 0; p < 2; p++) begin
            if (!rp[p] && $urandom_range(0, 2) == 0) begin
               rp[p]   = 1;
               rwe[p]  = 1'($urandom_range(0, 1));
               radr[p] = 32'h400 + 32'($urandom_range(0, 7) * 4);
               rwd[p]  = $urandom;
            end
         end
         bus.c_req = rp[0]; bus.c_we = rwe[0];
         bus.c_adr = radr[0]; bus.c_wdata = rwd[0];
         bus.d_req = rp[1]; bus.d_we = rwe[1];
         bus.d_adr = radr[1]; bus.d_wdata = rwd[1];
         if (t >= free_at && (rp[0] || rp[1])) begin
            if (rp[0] && rp[1]) win = 1 - rlast;
            else                win = rp[1] ? 1 : 0;
            rlast   = win;
            win_t   = t;
            done_t  = t + 1 + LAT;
            free_at = done_t + 1;
            busy    = 1;
            exp_a   = radr[win];
            exp_we  = rwe[win];
            exp_w   = rwd[win];
            if (rwe[win]) begin
               exp_d = wjunk(exp_a);
               ref_mem[exp_a] = exp_w;
            end else begin
               exp_d = ref_mem.exists(exp_a) ? ref_mem[exp_a] : dflt(exp_a);
            end
         end
      end
      clear_inputs();

      lat_go = 1'b1;
      for (int i = 0; i < 300 && !(lat_done[0] && lat_done[1]); i++)
         @(negedge clk);
      chk("lat_builds_done", lat_done[0] && lat_done[1], 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
